spi_master_multi_cs: RTL and testbench

Parametrised SPI master with N chip selects. Word width, CS count and burst depth are set by generics; SPI mode, SCLK divider and target CS are chosen per transaction at run time. Keeps CS asserted across a multi-word burst, then enforces a minimum CS-inactive gap. Sits between the core's peripheral bus bridge and external SPI pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_master_multi_cs_if.sv | 36 +++
 rtl/spi_sclk_gen.sv | 70 +++++++
 rtl/spi_master_multi_cs.sv | 160 ++++++++++++++++
 tb/tb_spi_master_multi_cs.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the multi-CS SPI master
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT_NEXT,
    ST_CS_GAP
  } spi_state_e;

  // A single chip select still needs a one-bit index port.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_multi_cs_if.sv
// rtl/spi_master_multi_cs_if.sv - bus-bridge side of the SPI master: transaction setup, TX/RX words, status
interface spi_master_multi_cs_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int NUM_CS           = 4,
  parameter int MAX_WORDS_PER_CS = 16,
  parameter int CLKDIV_WIDTH     = 8
);
  import spi_pkg::*;

  localparam int CSW = clog2_min1(NUM_CS);
  localparam int CW  = $clog2(MAX_WORDS_PER_CS + 1);

  logic [1:0]              i_Mode;
  logic [CLKDIV_WIDTH-1:0] i_Clks_Per_Half_Bit;
  logic [CSW-1:0]          i_CS_Sel;
  logic [CW-1:0]           i_TX_Count;
  logic [DATA_WIDTH-1:0]   i_TX_Word;
  logic                    i_TX_DV;
  logic                    o_TX_Ready;
  logic                    o_RX_DV;
  logic [DATA_WIDTH-1:0]   o_RX_Word;
  logic [CW-1:0]           o_RX_Count;
  logic                    o_Error;
  logic                    o_Busy;

  modport master (
    output i_Mode, i_Clks_Per_Half_Bit, i_CS_Sel, i_TX_Count, i_TX_Word, i_TX_DV,
    input  o_TX_Ready, o_RX_DV, o_RX_Word, o_RX_Count, o_Error, o_Busy
  );

  modport slave (
    input  i_Mode, i_Clks_Per_Half_Bit, i_CS_Sel, i_TX_Count, i_TX_Word, i_TX_DV,
    output o_TX_Ready, o_RX_DV, o_RX_Word, o_RX_Count, o_Error, o_Busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK generator: half-bit divider, edge counter, leading/trailing strobes
module spi_sclk_gen #(
  parameter int CLKDIV_WIDTH = 8,
  parameter int LEN_WIDTH    = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Start,
  input  logic [CLKDIV_WIDTH-1:0] i_Div,
  input  logic                    i_Cpol,
  input  logic [LEN_WIDTH-1:0]    i_Word_Len,
  output logic                    o_SPI_Clk,
  output logic                    o_Lead,
  output logic                    o_Trail,
  output logic                    o_Done
);
  localparam int EW = LEN_WIDTH + 1;

  logic                    r_active;
  logic                    r_sclk;
  logic                    r_done;
  logic [CLKDIV_WIDTH-1:0] r_div;
  logic [CLKDIV_WIDTH-1:0] r_half_cnt;
  logic [EW-1:0]           r_edge_cnt;
  logic [EW-1:0]           r_edge_total;
  logic                    w_edge;
  logic                    w_last;

  // Strobes fire in the cycle whose closing clock edge toggles SCLK.
  assign w_edge  = r_active && (r_half_cnt == r_div - CLKDIV_WIDTH'(1));
  assign w_last  = w_edge && (r_edge_cnt == r_edge_total - EW'(1));
  assign o_Lead  = w_edge && !r_edge_cnt[0];
  assign o_Trail = w_edge && r_edge_cnt[0];
  assign o_Done  = r_done;
  assign o_SPI_Clk = r_sclk;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_active     <= 1'b0;
      r_sclk       <= 1'b0;
      r_done       <= 1'b0;
      r_div        <= '0;
      r_half_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_edge_total <= '0;
    end else begin
      r_done <= w_last;
      if (i_Start) begin
        r_active     <= 1'b1;
        r_sclk       <= i_Cpol;
        r_div        <= i_Div;
        r_half_cnt   <= '0;
        r_edge_cnt   <= '0;
        r_edge_total <= {i_Word_Len, 1'b0};
      end else if (r_active) begin
        if (w_edge) begin
          r_half_cnt <= '0;
          r_edge_cnt <= r_edge_cnt + EW'(1);
          r_sclk     <= ~r_sclk;
          if (w_last) r_active <= 1'b0;
        end else begin
          r_half_cnt <= r_half_cnt + CLKDIV_WIDTH'(1);
        end
      end else begin
        r_sclk <= i_Cpol;
      end
    end
  end

endmodule

// File: rtl/spi_master_multi_cs.sv
// rtl/spi_master_multi_cs.sv - SPI master with N chip selects, CS held across bursts, enforced CS gap
module spi_master_multi_cs #(
  parameter int DATA_WIDTH       = 8,
  parameter int NUM_CS           = 4,
  parameter int MAX_WORDS_PER_CS = 16,
  parameter int CS_INACTIVE_CLKS = 10,
  parameter int CLKDIV_WIDTH     = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  spi_master_multi_cs_if.slave bus,
  output logic                 o_SPI_Clk,
  input  logic                 i_SPI_MISO,
  output logic                 o_SPI_MOSI,
  output logic [NUM_CS-1:0]    o_SPI_CS_n
);
  import spi_pkg::*;

  localparam int CSW = clog2_min1(NUM_CS);
  localparam int CW  = $clog2(MAX_WORDS_PER_CS + 1);
  localparam int LW  = $clog2(DATA_WIDTH + 1);
  localparam int GW  = $clog2(CS_INACTIVE_CLKS + 1);
  localparam logic [CLKDIV_WIDTH-1:0] MIN_DIV = CLKDIV_WIDTH'(2);
  localparam logic [CW-1:0]           MAX_CNT = CW'(MAX_WORDS_PER_CS);

  spi_state_e              r_state, w_state_next;
  spi_mode_t               r_mode, w_mode_eff;
  logic [CLKDIV_WIDTH-1:0] r_div, w_div_in, w_div_eff;
  logic [CSW-1:0]          r_cs_sel, w_sel_eff;
  logic [CW-1:0]           r_remaining, r_index, r_rx_count, w_count_in;
  logic [DATA_WIDTH-1:0]   r_tx_shift, r_rx_shift, r_rx_word;
  logic                    r_rx_dv, r_error, r_mosi;
  logic [NUM_CS-1:0]       r_cs_n, w_cs_low;
  logic [GW-1:0]           r_gap_cnt;
  logic                    w_start, w_err, w_lead, w_trail, w_done, w_sample, w_shift;

  assign w_div_in   = (bus.i_Clks_Per_Half_Bit < MIN_DIV) ? MIN_DIV : bus.i_Clks_Per_Half_Bit;
  assign w_count_in = (bus.i_TX_Count == '0) ? CW'(1) :
                      (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;
  // In IDLE the incoming request is used directly; afterwards the latched copy rules the burst.
  assign w_mode_eff = (r_state == ST_IDLE) ? spi_mode_t'(bus.i_Mode) : r_mode;
  assign w_div_eff  = (r_state == ST_IDLE) ? w_div_in : r_div;
  assign w_sel_eff  = (r_state == ST_IDLE) ? bus.i_CS_Sel : r_cs_sel;
  assign w_cs_low   = NUM_CS'(1) << w_sel_eff;
  assign w_sample   = w_mode_eff.cpha ? w_trail : w_lead;
  assign w_shift    = w_mode_eff.cpha ? w_lead : w_trail;

  spi_sclk_gen #(
    .CLKDIV_WIDTH(CLKDIV_WIDTH),
    .LEN_WIDTH   (LW)
  ) u_sclk_gen (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Start   (w_start),
    .i_Div     (w_div_eff),
    .i_Cpol    (w_mode_eff.cpol),
    .i_Word_Len(LW'(DATA_WIDTH)),
    .o_SPI_Clk (o_SPI_Clk),
    .o_Lead    (w_lead),
    .o_Trail   (w_trail),
    .o_Done    (w_done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_TX_DV) begin
          if (int'(bus.i_CS_Sel) >= NUM_CS) begin
            w_err = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_state_next = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (w_done) w_state_next = (r_remaining == CW'(1)) ? ST_CS_GAP : ST_WAIT_NEXT;
      end
      ST_WAIT_NEXT: begin
        if (bus.i_TX_DV) begin
          w_start      = 1'b1;
          w_state_next = ST_XFER;
        end
      end
      ST_CS_GAP: begin
        if (r_gap_cnt == GW'(CS_INACTIVE_CLKS - 1)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_mode      <= '0;
      r_div       <= '0;
      r_cs_sel    <= '0;
      r_remaining <= '0;
      r_index     <= '0;
      r_rx_count  <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_word   <= '0;
      r_rx_dv     <= 1'b0;
      r_error     <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_n      <= '1;
      r_gap_cnt   <= '0;
    end else begin
      r_rx_dv   <= 1'b0;
      r_error   <= w_err;
      r_cs_n    <= (w_state_next == ST_XFER || w_state_next == ST_WAIT_NEXT) ? ~w_cs_low : '1;
      r_gap_cnt <= (r_state == ST_CS_GAP) ? r_gap_cnt + GW'(1) : '0;
      if (r_state == ST_IDLE && bus.i_TX_DV) begin
        r_mode      <= spi_mode_t'(bus.i_Mode);
        r_div       <= w_div_in;
        r_cs_sel    <= bus.i_CS_Sel;
        r_remaining <= w_count_in;
        r_index     <= '0;
      end
      // CPHA=0 must present the MSB before the first edge; CPHA=1 waits for the leading edge.
      if (w_start) begin
        if (w_mode_eff.cpha) begin
          r_tx_shift <= bus.i_TX_Word;
        end else begin
          r_mosi     <= bus.i_TX_Word[DATA_WIDTH-1];
          r_tx_shift <= bus.i_TX_Word << 1;
        end
      end else if (w_shift) begin
        r_mosi     <= r_tx_shift[DATA_WIDTH-1];
        r_tx_shift <= r_tx_shift << 1;
      end
      if (w_sample) r_rx_shift <= DATA_WIDTH'({r_rx_shift, i_SPI_MISO});
      if (r_state == ST_XFER && w_done) begin
        r_rx_dv     <= 1'b1;
        r_rx_word   <= r_rx_shift;
        r_rx_count  <= r_index;
        r_index     <= r_index + CW'(1);
        r_remaining <= r_remaining - CW'(1);
      end
    end
  end

  assign bus.o_TX_Ready = (r_state == ST_IDLE) || (r_state == ST_WAIT_NEXT);
  assign bus.o_Busy     = (r_state != ST_IDLE);
  assign bus.o_RX_DV    = r_rx_dv;
  assign bus.o_RX_Word  = r_rx_word;
  assign bus.o_RX_Count = r_rx_count;
  assign bus.o_Error    = r_error;
  assign o_SPI_MOSI     = r_mosi;
  assign o_SPI_CS_n     = r_cs_n;

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// tb/tb_spi_master_multi_cs.sv - scoreboard bench for spi_master_multi_cs in MOSI-to-MISO loopback
module tb_spi_master_multi_cs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_multi_cs_if #(.DATA_WIDTH(8), .NUM_CS(4), .MAX_WORDS_PER_CS(16), .CLKDIV_WIDTH(8)) bus ();
  spi_master_multi_cs_if #(.DATA_WIDTH(8), .NUM_CS(3), .MAX_WORDS_PER_CS(16), .CLKDIV_WIDTH(8)) bus2 ();

  logic       sclk, mosi, sclk2, mosi2;
  logic [3:0] cs_n;
  logic [2:0] cs2_n;

  spi_master_multi_cs #(.DATA_WIDTH(8), .NUM_CS(4), .MAX_WORDS_PER_CS(16),
                        .CS_INACTIVE_CLKS(10), .CLKDIV_WIDTH(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .bus(bus), .o_SPI_Clk(sclk),
    .i_SPI_MISO(mosi), .o_SPI_MOSI(mosi), .o_SPI_CS_n(cs_n)
  );

  // Three chip selects leave index 3 out of range on a 2-bit select port.
  spi_master_multi_cs #(.DATA_WIDTH(8), .NUM_CS(3), .MAX_WORDS_PER_CS(16),
                        .CS_INACTIVE_CLKS(10), .CLKDIV_WIDTH(8)) dut2 (
    .i_Clk(clk), .i_Rst(rst), .bus(bus2), .o_SPI_Clk(sclk2),
    .i_SPI_MISO(mosi2), .o_SPI_MOSI(mosi2), .o_SPI_CS_n(cs2_n)
  );

  typedef struct {
    logic [7:0] word;
    logic [4:0] idx;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rx_seen = 0;
  int   rx2_seen = 0;
  int   st_rises, st_period, st_gap, st_csbad, st_first_fall, st_first_mosi, st_cyc;
  logic st_sclk_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_RX_DV) begin
      rx_seen++;
      if (sb_q.size() == 0) begin
        chk("rx_unexpected", 32'(bus.o_RX_DV), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rx_word", 32'(bus.o_RX_Word), 32'(mon_e.word));
        chk("rx_count", 32'(bus.o_RX_Count), 32'(mon_e.idx));
      end
    end
    if (!rst && bus2.o_RX_DV) rx2_seen++;
  end

  task automatic run_xfer(input logic [1:0] mode, input logic [7:0] div, input logic [1:0] sel,
                          input logic [4:0] cnt, input logic [7:0] w0, input logic [7:0] w1,
                          input int nwords, input bit spam);
    int         sent;
    int         last_rise;
    logic       p_sclk, p_mosi;
    logic [3:0] exp_cs;
    bit         in_gap;
    exp_cs = ~(4'b0001 << sel);
    st_rises = 0; st_period = 0; st_gap = 0; st_csbad = 0;
    st_first_fall = -1; st_first_mosi = -1; st_cyc = 0;
    last_rise = 0; in_gap = 0; sent = 1;
    @(negedge clk);
    p_sclk = sclk;
    p_mosi = mosi;
    bus.i_Mode = mode; bus.i_Clks_Per_Half_Bit = div; bus.i_CS_Sel = sel;
    bus.i_TX_Count = cnt; bus.i_TX_Word = w0; bus.i_TX_DV = 1'b1;
    sb_q.push_back('{w0, 5'd0});
    while (st_cyc < 3000) begin
      @(negedge clk);
      st_cyc++;
      bus.i_TX_DV = 1'b0;
      if (!bus.o_Busy) break;
      if (sclk && !p_sclk) begin
        if (last_rise > 0) st_period = st_cyc - last_rise;
        last_rise = st_cyc;
        st_rises++;
      end
      if (!sclk && p_sclk && st_first_fall < 0) st_first_fall = st_cyc;
      if (mosi != p_mosi && st_first_mosi < 0) st_first_mosi = st_cyc;
      if (cs_n == 4'b1111) begin
        in_gap = 1;
        st_gap++;
      end else if (cs_n != exp_cs || in_gap) begin
        st_csbad++;
      end
      if (spam && (st_cyc == 3 || st_cyc == 5)) begin
        bus.i_TX_Word = 8'hEE;
        bus.i_TX_DV = 1'b1;
      end
      if (bus.o_TX_Ready && sent < nwords) begin
        bus.i_TX_Word = w1;
        bus.i_TX_DV = 1'b1;
        sb_q.push_back('{w1, 5'(sent)});
        sent++;
      end
      p_sclk = sclk;
      p_mosi = mosi;
    end
    chk("xfer_timeout", 32'(bus.o_Busy), 32'd0);
    st_sclk_end = sclk;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, guard, toggles, bad, seen0;
    logic p;
    bus.i_Mode = 2'b00; bus.i_Clks_Per_Half_Bit = 8'd4; bus.i_CS_Sel = '0;
    bus.i_TX_Count = '0; bus.i_TX_Word = '0; bus.i_TX_DV = 1'b0;
    bus2.i_Mode = 2'b00; bus2.i_Clks_Per_Half_Bit = 8'd4; bus2.i_CS_Sel = '0;
    bus2.i_TX_Count = '0; bus2.i_TX_Word = '0; bus2.i_TX_DV = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ready", 32'(bus.o_TX_Ready), 32'd1);
    chk("rst_rx_dv", 32'(bus.o_RX_DV), 32'd0);
    chk("rst_error", 32'(bus.o_Error), 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_rx_word", 32'(bus.o_RX_Word), 32'd0);
    chk("rst_rx_count", 32'(bus.o_RX_Count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(2'b00, 8'd4, 2'd2, 5'd2, 8'hA5, 8'h3C, 2, 1'b0);
    chk("m0_cs_pattern", st_csbad, 0);
    chk("m0_cs_gap", st_gap, 10);
    chk("m0_sclk_rises", st_rises, 16);
    chk("m0_sclk_period", st_period, 8);
    chk("m0_sb_empty", sb_q.size(), 0);

    @(negedge clk);
    bus.i_Mode = 2'b11;
    repeat (2) @(negedge clk);
    chk("m3_idle_pre", 32'(sclk), 32'd1);
    run_xfer(2'b11, 8'd2, 2'd0, 5'd1, 8'hC1, 8'h00, 1, 1'b0);
    chk("m3_idle_post", 32'(st_sclk_end), 32'd1);
    chk("m3_fall_seen", 32'(st_first_fall > 0), 32'd1);
    chk("m3_first_mosi", st_first_mosi, st_first_fall);
    chk("m3_sclk_rises", st_rises, 8);
    chk("m3_sb_empty", sb_q.size(), 0);

    run_xfer(2'b01, 8'd1, 2'd3, 5'd1, 8'h81, 8'h00, 1, 1'b0);
    chk("div1_period", st_period, 4);
    chk("div1_rises", st_rises, 8);
    chk("div1_sb_empty", sb_q.size(), 0);

    @(negedge clk);
    bus2.i_Mode = 2'b00; bus2.i_CS_Sel = 2'd3; bus2.i_TX_Count = 5'd1;
    bus2.i_TX_Word = 8'h55; bus2.i_TX_DV = 1'b1;
    @(negedge clk);
    bus2.i_TX_DV = 1'b0;
    chk("err_pulse", 32'(bus2.o_Error), 32'd1);
    chk("err_cs", 32'(cs2_n), 32'h7);
    @(negedge clk);
    chk("err_one_cycle", 32'(bus2.o_Error), 32'd0);
    toggles = 0; bad = 0; p = sclk2;
    repeat (30) begin
      @(negedge clk);
      if (sclk2 != p) toggles++;
      if (cs2_n != 3'b111) bad++;
      p = sclk2;
    end
    chk("err_no_sclk", toggles, 0);
    chk("err_cs_hold", bad, 0);
    chk("err_no_rx", rx2_seen, 0);
    chk("err_idle", 32'(bus2.o_Busy), 32'd0);

    @(negedge clk);
    bus.i_Mode = 2'b00; bus.i_Clks_Per_Half_Bit = 8'd4; bus.i_CS_Sel = 2'd1;
    bus.i_TX_Count = 5'd2; bus.i_TX_Word = 8'h5A; bus.i_TX_DV = 1'b1;
    p = sclk;
    @(negedge clk);
    bus.i_TX_DV = 1'b0;
    edges = 0; guard = 0;
    if (sclk != p) edges++;
    p = sclk;
    while (edges < 3 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (sclk != p) edges++;
      p = sclk;
    end
    chk("rst_mid_edges", edges, 3);
    seen0 = rx_seen;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs_n", 32'(cs_n), 32'hF);
    chk("rst_mid_sclk", 32'(sclk), 32'd0);
    chk("rst_mid_ready", 32'(bus.o_TX_Ready), 32'd1);
    chk("rst_mid_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_mid_rx_dv", 32'(bus.o_RX_DV), 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_no_rx", rx_seen - seen0, 0);

    seen0 = rx_seen;
    run_xfer(2'b00, 8'd4, 2'd0, 5'd0, 8'h96, 8'h00, 1, 1'b1);
    chk("cnt0_one_rx", rx_seen - seen0, 1);
    chk("cnt0_rises", st_rises, 8);
    chk("cnt0_sb_empty", sb_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
